// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared constants and width helpers for the debouncer bank.
//               DEBOUNCE_SYNC_STAGES - depth of the per-channel synchroniser.
//               clog2 / cnt_width    - counter sizing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  localparam int DEBOUNCE_SYNC_STAGES = 2;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Counter width able to hold 0..value-1, never narrower than one bit.
  function automatic int cnt_width(input int value);
    int w;
    w = clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One debounced bit. Synchroniser, saturating stability counter
//               advanced by the shared sample tick, clean level register and
//               registered one-cycle rise/fall pulses.
// Ports       : CLK, RESETN (sync, active-low)
//               tick       - shared prescaler sample strobe
//               signal_in  - raw asynchronous input bit
//               level      - debounced level
//               rise, fall - one-cycle pulses coincident with level edges
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = 16,
  parameter bit INIT_LEVEL = 1'b0
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic tick,
  input  logic signal_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int                CW       = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0]     CNT_LAST = CW'(STABLE_CNT - 1);
  localparam int                NS       = DEBOUNCE_SYNC_STAGES;

  logic [NS-1:0] sync;
  logic [CW-1:0] cnt;
  logic          synced;

  assign synced = sync[NS-1];

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sync  <= {NS{INIT_LEVEL}};
      level <= INIT_LEVEL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[NS-2:0], signal_in};
      rise <= 1'b0;
      fall <= 1'b0;
      // A single cycle agreeing with the current level aborts any pending
      // change; this also wins over a coincident tick.
      if (synced == level) begin
        cnt <= '0;
      end else if (tick && (cnt == CNT_LAST)) begin
        level <= synced;
        cnt   <= '0;
        rise  <= synced;
        fall  <= ~synced;
      end else if (tick) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bank
// Description : Multi-channel debouncer. A shared prescaler produces the
//               sample tick; each bit is handled by a debounce_channel.
// Ports       : CLK, RESETN (sync, active-low)
//               SIGNAL_I [N_CH] - raw asynchronous inputs
//               SIGNAL_O [N_CH] - debounced levels
//               RISE_O   [N_CH] - one-cycle pulse on 0->1 of SIGNAL_O
//               FALL_O   [N_CH] - one-cycle pulse on 1->0 of SIGNAL_O
//               CHANGE_O        - any edge pulse, one cycle later
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int STABLE_CNT = 16,
  parameter int PRESCALE   = 1000,
  parameter bit INIT_LEVEL = 1'b0
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic [N_CH-1:0] SIGNAL_I,
  output logic [N_CH-1:0] SIGNAL_O,
  output logic [N_CH-1:0] RISE_O,
  output logic [N_CH-1:0] FALL_O,
  output logic            CHANGE_O
);

  if (STABLE_CNT < 1) begin : g_bad_stable_cnt
    $error("debounce_bank: STABLE_CNT must be >= 1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("debounce_bank: PRESCALE must be >= 1");
  end
  if (N_CH < 1) begin : g_bad_n_ch
    $error("debounce_bank: N_CH must be >= 1");
  end

  logic tick;

  if (PRESCALE == 1) begin : g_tick_always
    assign tick = 1'b1;
  end else begin : g_prescaler
    localparam int            PW        = cnt_width(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge CLK) begin
      if (!RESETN) begin
        pre_cnt <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_channel
    debounce_channel #(
      .STABLE_CNT (STABLE_CNT),
      .INIT_LEVEL (INIT_LEVEL)
    ) u_channel (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .tick      (tick),
      .signal_in (SIGNAL_I[i]),
      .level     (SIGNAL_O[i]),
      .rise      (RISE_O[i]),
      .fall      (FALL_O[i])
    );
  end

  // Simultaneous edges on several channels still yield a single-cycle strobe.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      CHANGE_O <= 1'b0;
    end else begin
      CHANGE_O <= |(RISE_O | FALL_O);
    end
  end

endmodule
`default_nettype wire
